regfile_bank_n: RTL and testbench

Architectural register storage for the datapath: 32 entries of n bits with one synchronous write port, a hardwired-zero entry 0, and a per-register busy scoreboard. It sits directly upstream of the two 32-to-1 read multiplexers. It drives all 32 register values as an unpacked array, which both read muxes consume unchanged. It also raises a stall when either source operand of the issuing instruction has a pending write-back.

---
 rtl/ctmt_pkg.sv | 9 +
 rtl/regfile_bank_n_dec5to32.sv | 19 +
 rtl/regfile_bank_n.sv | 79 +++++++
 tb/tb_regfile_bank_n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ctmt_pkg.sv
// Shared register-file constants and address type.
package ctmt_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_bank_n_dec5to32.sv
// One-hot address decoder with enable; all-zero output when disabled.
module dec5to32
    import ctmt_pkg::*;
#(
    parameter int AW = REG_ADDR_W
) (
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    output logic [2**AW-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_bank_n.sv
// 32-entry register bank with hardwired x0 and per-register busy scoreboard.
module regfile_bank_n
    import ctmt_pkg::*;
#(
    parameter int n       = 32,
    parameter int address = REG_ADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [address-1:0] wr_addr_i,
    input  logic [n-1:0]       wr_data_i,
    input  logic               busy_set_i,
    input  logic [address-1:0] busy_addr_i,
    input  logic [address-1:0] rs1_addr_i,
    input  logic [address-1:0] rs2_addr_i,
    output logic [n-1:0]       regs_o [0:2**address-1],
    output logic [2**address-1:0] busy_o,
    output logic               stall_o
);

    localparam int N = 2 ** address;
    localparam logic [N-1:0] X0_MASK = {{(N-1){1'b1}}, 1'b0};

    logic [n-1:0] r_regs [0:N-1];
    logic [N-1:0] r_busy;
    logic [N-1:0] w_we;
    logic [N-1:0] w_set;

    dec5to32 #(.AW(address)) u_dec_we (
        .en_i     (wr_en_i),
        .addr_i   (wr_addr_i),
        .onehot_o (w_we)
    );

    dec5to32 #(.AW(address)) u_dec_set (
        .en_i     (busy_set_i),
        .addr_i   (busy_addr_i),
        .onehot_o (w_set)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_we[k] && k != 0) begin
                    r_regs[k] <= wr_data_i;
                end
            end
        end
    end

    // A new producer outranks a retiring one on the same register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= (w_set | (r_busy & ~w_we)) & X0_MASK;
        end
    end

    always_comb begin
        regs_o[0] = '0;
        for (int k = 1; k < N; k++) begin
            regs_o[k] = r_regs[k];
        end
    end

    assign busy_o = r_busy;

    always_comb begin
        stall_o = ((rs1_addr_i != '0) && r_busy[rs1_addr_i]) ||
                  ((rs2_addr_i != '0) && r_busy[rs2_addr_i]);
    end

endmodule

// File: tb/tb_regfile_bank_n.sv
// Directed-vector bench for regfile_bank_n.
module tb_regfile_bank_n;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        busy_set_i;
    logic [4:0]  busy_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] regs_o [0:31];
    logic [31:0] busy_o;
    logic        stall_o;

    int n_vec = 0;
    int n_err = 0;

    regfile_bank_n #(.n(32), .address(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .busy_set_i  (busy_set_i),
        .busy_addr_i (busy_addr_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .regs_o      (regs_o),
        .busy_o      (busy_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i    = 1'b0;
        busy_set_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        wr_en_i     = 1'b1;
        wr_addr_i   = 5'd3;
        wr_data_i   = 32'hFFFF_FFFF;
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd3;
        rs1_addr_i  = 5'd3;
        rs2_addr_i  = 5'd0;

        // reset wins over concurrent write and busy set
        tick();
        tick();
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("rst_reg%0d", k), regs_o[k], 32'h0);
        end
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);

        rst_i = 1'b0;
        idle();
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd5;
        wr_data_i = 32'hDEAD_BEEF;
        #1;
        chk("no_comb_path", regs_o[5], 32'h0);
        tick();
        idle();
        chk("wr_x5", regs_o[5], 32'hDEAD_BEEF);
        chk("wr_x4_hold", regs_o[4], 32'h0);
        chk("wr_x6_hold", regs_o[6], 32'h0);

        wr_en_i   = 1'b1;
        wr_addr_i = 5'd0;
        wr_data_i = 32'h1234_5678;
        tick();
        idle();
        chk("wr_x0_drop", regs_o[0], 32'h0);
        chk("x5_keep", regs_o[5], 32'hDEAD_BEEF);

        // rs1 scoreboard on x7
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd7;
        rs1_addr_i  = 5'd7;
        rs2_addr_i  = 5'd0;
        #1;
        chk("set_not_yet", {31'h0, stall_o}, 32'h0);
        tick();
        idle();
        chk("busy_x7", busy_o, 32'h0000_0080);
        chk("stall_x7", {31'h0, stall_o}, 32'h1);
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd7;
        wr_data_i = 32'h0000_0077;
        #1;
        chk("no_bypass", {31'h0, stall_o}, 32'h1);
        tick();
        idle();
        chk("wb_x7_stall", {31'h0, stall_o}, 32'h0);
        chk("wb_x7_busy", busy_o, 32'h0);
        chk("wb_x7_data", regs_o[7], 32'h0000_0077);

        // rs2 scoreboard on x8
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd8;
        rs1_addr_i  = 5'd0;
        rs2_addr_i  = 5'd8;
        tick();
        idle();
        chk("stall_rs2", {31'h0, stall_o}, 32'h1);
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd8;
        wr_data_i = 32'h0000_0088;
        tick();
        idle();
        chk("clr_rs2", {31'h0, stall_o}, 32'h0);

        // set and clear together on x9
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd9;
        tick();
        idle();
        wr_en_i     = 1'b1;
        wr_addr_i   = 5'd9;
        wr_data_i   = 32'hA5A5_A5A5;
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd9;
        tick();
        idle();
        chk("setclr_data", regs_o[9], 32'hA5A5_A5A5);
        chk("setclr_busy", busy_o, 32'h0000_0200);

        // late write to an idle register
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd10;
        wr_data_i = 32'h0000_1010;
        tick();
        idle();
        chk("late_data", regs_o[10], 32'h0000_1010);
        chk("late_busy", busy_o, 32'h0000_0200);

        // busy on x0 is ignored
        busy_set_i  = 1'b1;
        busy_addr_i = 5'd0;
        rs1_addr_i  = 5'd0;
        rs2_addr_i  = 5'd0;
        tick();
        idle();
        chk("x0_busy", busy_o, 32'h0000_0200);
        chk("x0_stall", {31'h0, stall_o}, 32'h0);

        // reset discards pending busy bits
        busy_set_i = 1'b1;
        busy_addr_i = 5'd1;
        tick();
        busy_addr_i = 5'd2;
        tick();
        busy_addr_i = 5'd31;
        tick();
        idle();
        rs1_addr_i = 5'd1;
        rs2_addr_i = 5'd31;
        #1;
        chk("pre_rst_busy", busy_o, 32'h8000_0206);
        chk("pre_rst_stall", {31'h0, stall_o}, 32'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_busy", busy_o, 32'h0);
        chk("mid_rst_stall", {31'h0, stall_o}, 32'h0);
        chk("mid_rst_x5", regs_o[5], 32'h0);
        tick();
        chk("post_rst_stall", {31'h0, stall_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
